// File: rtl/reservation_station_if.sv
// Dispatch, CDB and ALU-issue signal bundle for the reservation station.
// master = environment (dispatcher, RoB, CDB, ALU side); slave = reservation station.
interface reservation_station_if #(
  parameter int unsigned RoB_WIDTH = 3
);
  logic                 rdy_in;
  logic                 RoB_flush_signal;

  logic                 RS_newEntry_en;
  logic [RoB_WIDTH-1:0] RS_robEntry;
  logic [6:0]           RS_opcode;
  logic [31:0]          RS_Vj;
  logic [31:0]          RS_Vk;
  logic [RoB_WIDTH:0]   RS_Qj;
  logic [RoB_WIDTH:0]   RS_Qk;
  logic [31:0]          RS_imm;
  logic [31:0]          RS_pc;
  logic                 RS_isFull;

  logic                 ALU_cdb_en;
  logic [RoB_WIDTH-1:0] ALU_cdb_robIndex;
  logic [31:0]          ALU_cdb_value;
  logic                 LSB_cdb_en;
  logic [RoB_WIDTH-1:0] LSB_cdb_robIndex;
  logic [31:0]          LSB_cdb_value;

  logic                 ALU_en;
  logic [RoB_WIDTH-1:0] ALU_robIndex;
  logic [6:0]           ALU_opcode;
  logic [31:0]          ALU_Vj;
  logic [31:0]          ALU_Vk;
  logic [31:0]          ALU_imm;
  logic [31:0]          ALU_pc;

  modport master (
    output rdy_in, RoB_flush_signal,
    output RS_newEntry_en, RS_robEntry, RS_opcode, RS_Vj, RS_Vk, RS_Qj, RS_Qk, RS_imm, RS_pc,
    input  RS_isFull,
    output ALU_cdb_en, ALU_cdb_robIndex, ALU_cdb_value,
    output LSB_cdb_en, LSB_cdb_robIndex, LSB_cdb_value,
    input  ALU_en, ALU_robIndex, ALU_opcode, ALU_Vj, ALU_Vk, ALU_imm, ALU_pc
  );

  modport slave (
    input  rdy_in, RoB_flush_signal,
    input  RS_newEntry_en, RS_robEntry, RS_opcode, RS_Vj, RS_Vk, RS_Qj, RS_Qk, RS_imm, RS_pc,
    output RS_isFull,
    input  ALU_cdb_en, ALU_cdb_robIndex, ALU_cdb_value,
    input  LSB_cdb_en, LSB_cdb_robIndex, LSB_cdb_value,
    output ALU_en, ALU_robIndex, ALU_opcode, ALU_Vj, ALU_Vk, ALU_imm, ALU_pc
  );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched ops, snoops two CDB ports for operands,
// and issues the lowest-index ready entry to the ALU each cycle.
module reservation_station #(
  parameter int unsigned RS_WIDTH  = 2,
  parameter int unsigned RoB_WIDTH = 3,
  parameter int unsigned NON_DEP   = 1 << RoB_WIDTH
) (
  input logic                  clk_in,
  input logic                  rst_in,
  reservation_station_if.slave bus
);
  localparam int unsigned SIZE = 1 << RS_WIDTH;
  localparam int unsigned QW   = RoB_WIDTH + 1;
  localparam logic [QW-1:0] NonDep = QW'(NON_DEP);

  typedef struct packed {
    logic                 busy;
    logic [RoB_WIDTH-1:0] rob;
    logic [6:0]           opcode;
    logic [31:0]          vj;
    logic [31:0]          vk;
    logic [QW-1:0]        qj;
    logic [QW-1:0]        qk;
    logic [31:0]          imm;
    logic [31:0]          pc;
  } entry_t;

  typedef struct packed {
    logic [RoB_WIDTH-1:0] rob;
    logic [6:0]           opcode;
    logic [31:0]          vj;
    logic [31:0]          vk;
    logic [31:0]          imm;
    logic [31:0]          pc;
  } issue_t;

  localparam entry_t EntryRst = '{busy: 1'b0, rob: '0, opcode: '0, vj: '0, vk: '0,
                                  qj: NonDep, qk: NonDep, imm: '0, pc: '0};

  entry_t [SIZE-1:0] ent_q, ent_d;
  issue_t            iss_q, iss_d;
  logic              alu_en_q, alu_en_d;

  logic [RS_WIDTH:0]   busy_count;
  logic [SIZE-1:0]     ready;
  logic                sel_valid;
  logic [RS_WIDTH-1:0] sel_idx;
  logic                free_valid;
  logic [RS_WIDTH-1:0] free_idx;

  // Tags carry an extra MSB so a producer tag can never alias NON_DEP.
  function automatic logic tag_hit(input logic [QW-1:0] q, input logic en,
                                   input logic [RoB_WIDTH-1:0] idx);
    return en && (q == {1'b0, idx});
  endfunction

  // Descending scan so the lowest matching index wins.
  always_comb begin
    busy_count = '0;
    ready      = '0;
    sel_valid  = 1'b0;
    sel_idx    = '0;
    free_valid = 1'b0;
    free_idx   = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      ready[i]   = ent_q[i].busy && (ent_q[i].qj == NonDep) && (ent_q[i].qk == NonDep);
      busy_count = busy_count + {{RS_WIDTH{1'b0}}, ent_q[i].busy};
      if (ready[i]) begin
        sel_valid = 1'b1;
        sel_idx   = RS_WIDTH'(i);
      end
      if (!ent_q[i].busy) begin
        free_valid = 1'b1;
        free_idx   = RS_WIDTH'(i);
      end
    end
  end

  // Counts the in-flight dispatch so the dispatcher's one-cycle register delay cannot overfill.
  assign bus.RS_isFull = ({1'b0, busy_count} + (RS_WIDTH + 2)'(bus.RS_newEntry_en))
                         >= (RS_WIDTH + 2)'(SIZE);

  always_comb begin
    ent_d    = ent_q;
    iss_d    = iss_q;
    alu_en_d = alu_en_q;
    if (bus.rdy_in) begin
      if (bus.RoB_flush_signal) begin
        for (int i = 0; i < SIZE; i++) ent_d[i].busy = 1'b0;
        alu_en_d = 1'b0;
      end else begin
        for (int i = 0; i < SIZE; i++) begin
          if (ent_q[i].busy) begin
            if (tag_hit(ent_q[i].qj, bus.ALU_cdb_en, bus.ALU_cdb_robIndex)) begin
              ent_d[i].vj = bus.ALU_cdb_value;
              ent_d[i].qj = NonDep;
            end else if (tag_hit(ent_q[i].qj, bus.LSB_cdb_en, bus.LSB_cdb_robIndex)) begin
              ent_d[i].vj = bus.LSB_cdb_value;
              ent_d[i].qj = NonDep;
            end
            if (tag_hit(ent_q[i].qk, bus.ALU_cdb_en, bus.ALU_cdb_robIndex)) begin
              ent_d[i].vk = bus.ALU_cdb_value;
              ent_d[i].qk = NonDep;
            end else if (tag_hit(ent_q[i].qk, bus.LSB_cdb_en, bus.LSB_cdb_robIndex)) begin
              ent_d[i].vk = bus.LSB_cdb_value;
              ent_d[i].qk = NonDep;
            end
          end
        end

        alu_en_d = sel_valid;
        if (sel_valid) begin
          iss_d = '{rob: ent_q[sel_idx].rob, opcode: ent_q[sel_idx].opcode,
                    vj: ent_q[sel_idx].vj, vk: ent_q[sel_idx].vk,
                    imm: ent_q[sel_idx].imm, pc: ent_q[sel_idx].pc};
          ent_d[sel_idx].busy = 1'b0;
        end

        // free_idx comes from registered busy bits, so a slot issued this edge stays empty.
        if (bus.RS_newEntry_en && free_valid) begin
          ent_d[free_idx].busy   = 1'b1;
          ent_d[free_idx].rob    = bus.RS_robEntry;
          ent_d[free_idx].opcode = bus.RS_opcode;
          ent_d[free_idx].imm    = bus.RS_imm;
          ent_d[free_idx].pc     = bus.RS_pc;
          ent_d[free_idx].vj     = bus.RS_Vj;
          ent_d[free_idx].qj     = bus.RS_Qj;
          ent_d[free_idx].vk     = bus.RS_Vk;
          ent_d[free_idx].qk     = bus.RS_Qk;
          if (tag_hit(bus.RS_Qj, bus.ALU_cdb_en, bus.ALU_cdb_robIndex)) begin
            ent_d[free_idx].vj = bus.ALU_cdb_value;
            ent_d[free_idx].qj = NonDep;
          end else if (tag_hit(bus.RS_Qj, bus.LSB_cdb_en, bus.LSB_cdb_robIndex)) begin
            ent_d[free_idx].vj = bus.LSB_cdb_value;
            ent_d[free_idx].qj = NonDep;
          end
          if (tag_hit(bus.RS_Qk, bus.ALU_cdb_en, bus.ALU_cdb_robIndex)) begin
            ent_d[free_idx].vk = bus.ALU_cdb_value;
            ent_d[free_idx].qk = NonDep;
          end else if (tag_hit(bus.RS_Qk, bus.LSB_cdb_en, bus.LSB_cdb_robIndex)) begin
            ent_d[free_idx].vk = bus.LSB_cdb_value;
            ent_d[free_idx].qk = NonDep;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ent_q    <= {SIZE{EntryRst}};
      iss_q    <= '0;
      alu_en_q <= 1'b0;
    end else begin
      ent_q    <= ent_d;
      iss_q    <= iss_d;
      alu_en_q <= alu_en_d;
    end
  end

  assign bus.ALU_en       = alu_en_q;
  assign bus.ALU_robIndex = iss_q.rob;
  assign bus.ALU_opcode   = iss_q.opcode;
  assign bus.ALU_Vj       = iss_q.vj;
  assign bus.ALU_Vk       = iss_q.vk;
  assign bus.ALU_imm      = iss_q.imm;
  assign bus.ALU_pc       = iss_q.pc;
endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: expected issues are queued at dispatch
// and compared (including the issue cycle) whenever ALU_en is seen high.
module tb_reservation_station;
  localparam int unsigned RoBW = 3;
  localparam logic [3:0]  ND   = 4'd8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reservation_station_if #(.RoB_WIDTH(RoBW)) bus ();

  reservation_station #(
    .RS_WIDTH (2),
    .RoB_WIDTH(RoBW),
    .NON_DEP  (8)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    int          at;
    logic [2:0]  rob;
    logic [6:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_issue(input int at, input logic [2:0] rob, input logic [6:0] op,
                              input logic [31:0] vj, input logic [31:0] vk,
                              input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    e = '{at: at, rob: rob, op: op, vj: vj, vk: vk, imm: imm, pc: pc};
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.rdy_in           = 1'b1;
    bus.RoB_flush_signal = 1'b0;
    bus.RS_newEntry_en   = 1'b0;
    bus.ALU_cdb_en       = 1'b0;
    bus.LSB_cdb_en       = 1'b0;
  endtask

  task automatic wr(input logic [2:0] rob, input logic [6:0] op, input logic [31:0] vj,
                    input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk,
                    input logic [31:0] imm, input logic [31:0] pc);
    bus.RS_newEntry_en = 1'b1;
    bus.RS_robEntry    = rob;
    bus.RS_opcode      = op;
    bus.RS_Vj          = vj;
    bus.RS_Vk          = vk;
    bus.RS_Qj          = qj;
    bus.RS_Qk          = qk;
    bus.RS_imm         = imm;
    bus.RS_pc          = pc;
  endtask

  task automatic alu_cdb(input logic [2:0] idx, input logic [31:0] val);
    bus.ALU_cdb_en       = 1'b1;
    bus.ALU_cdb_robIndex = idx;
    bus.ALU_cdb_value    = val;
  endtask

  task automatic lsb_cdb(input logic [2:0] idx, input logic [31:0] val);
    bus.LSB_cdb_en       = 1'b1;
    bus.LSB_cdb_robIndex = idx;
    bus.LSB_cdb_value    = val;
  endtask

  // Issue monitor: every ALU_en must match the oldest queued expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (bus.ALU_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 32'(bus.ALU_en), 32'd0);
      end else begin
        e = sb.pop_front();
        check("issue_cycle", cyc, e.at);
        check("issue_rob", 32'(bus.ALU_robIndex), 32'(e.rob));
        check("issue_op", 32'(bus.ALU_opcode), 32'(e.op));
        check("issue_vj", bus.ALU_Vj, e.vj);
        check("issue_vk", bus.ALU_Vk, e.vk);
        check("issue_imm", bus.ALU_imm, e.imm);
        check("issue_pc", bus.ALU_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.RS_robEntry      = '0;
    bus.RS_opcode        = '0;
    bus.RS_Vj            = '0;
    bus.RS_Vk            = '0;
    bus.RS_Qj            = ND;
    bus.RS_Qk            = ND;
    bus.RS_imm           = '0;
    bus.RS_pc            = '0;
    bus.ALU_cdb_robIndex = '0;
    bus.ALU_cdb_value    = '0;
    bus.LSB_cdb_robIndex = '0;
    bus.LSB_cdb_value    = '0;
    quiet();

    // Reset state
    repeat (2) step();
    check("rst_alu_en", 32'(bus.ALU_en), 32'd0);
    check("rst_alu_rob", 32'(bus.ALU_robIndex), 32'd0);
    check("rst_alu_vj", bus.ALU_Vj, 32'd0);
    check("rst_alu_pc", bus.ALU_pc, 32'd0);
    check("rst_full", 32'(bus.RS_isFull), 32'd0);
    rst_n = 1'b1;

    // Ready add issues one edge after the write
    wr(3'd2, 7'h01, 32'd5, 32'd7, ND, ND, 32'h100, 32'h8000);
    check("full_after_reset", 32'(bus.RS_isFull), 32'd0);
    expect_issue(cyc + 2, 3'd2, 7'h01, 32'd5, 32'd7, 32'h100, 32'h8000);
    step(); quiet();
    check("t1_no_early", 32'(bus.ALU_en), 32'd0);
    step();
    check("t1_en", 32'(bus.ALU_en), 32'd1);
    step();
    check("t1_en_drop", 32'(bus.ALU_en), 32'd0);

    // Wake-up of Qj from the ALU CDB
    wr(3'd1, 7'h02, 32'd0, 32'd9, 4'd3, ND, 32'd0, 32'h8004);
    step(); quiet();
    step();
    check("t2_wait", 32'(bus.ALU_en), 32'd0);
    alu_cdb(3'd3, 32'h10);
    expect_issue(cyc + 2, 3'd1, 7'h02, 32'h10, 32'd9, 32'd0, 32'h8004);
    step(); quiet();
    check("t2_wake_edge", 32'(bus.ALU_en), 32'd0);
    step();
    check("t2_en", 32'(bus.ALU_en), 32'd1);
    step();

    // Same-cycle forwarding from the LSB CDB into the new entry
    wr(3'd5, 7'h03, 32'h22, 32'd0, ND, 4'd4, 32'h4, 32'h8008);
    lsb_cdb(3'd4, 32'hAB);
    expect_issue(cyc + 2, 3'd5, 7'h03, 32'h22, 32'hAB, 32'h4, 32'h8008);
    step(); quiet();
    step();
    check("t3_en", 32'(bus.ALU_en), 32'd1);
    step();

    // Fill to capacity; the fifth write is dropped
    for (int k = 0; k < 4; k++) begin
      wr(3'(k), 7'(8'h10 + k), 32'd0, 32'(8'h30 + k), 4'd6, ND, 32'(k), 32'(32'h9000 + 4 * k));
      check("fill_full", 32'(bus.RS_isFull), 32'(k == 3));
      step();
    end
    wr(3'd4, 7'h14, 32'd0, 32'h34, 4'd6, ND, 32'd4, 32'h9010);
    check("full_fifth", 32'(bus.RS_isFull), 32'd1);
    step(); quiet();
    check("full_held", 32'(bus.RS_isFull), 32'd1);
    alu_cdb(3'd6, 32'h66);
    for (int k = 0; k < 4; k++)
      expect_issue(cyc + 2 + k, 3'(k), 7'(8'h10 + k), 32'h66, 32'(8'h30 + k), 32'(k),
                   32'(32'h9000 + 4 * k));
    step(); quiet();
    check("t4_wake_edge", 32'(bus.ALU_en), 32'd0);
    step();
    check("full_drain", 32'(bus.RS_isFull), 32'd0);
    repeat (3) step();
    step();
    check("t4_idle", 32'(bus.ALU_en), 32'd0);

    // Flush discards entries, the concurrent write and the concurrent broadcast
    wr(3'd1, 7'h20, 32'd0, 32'd1, 4'd7, ND, 32'd0, 32'd0);
    step();
    wr(3'd2, 7'h21, 32'd0, 32'd2, 4'd7, ND, 32'd0, 32'd0);
    step();
    wr(3'd3, 7'h22, 32'd1, 32'd2, ND, ND, 32'd0, 32'd0);
    bus.RoB_flush_signal = 1'b1;
    alu_cdb(3'd7, 32'h77);
    step(); quiet();
    check("flush_alu_en", 32'(bus.ALU_en), 32'd0);
    check("flush_full", 32'(bus.RS_isFull), 32'd0);
    lsb_cdb(3'd7, 32'h78);
    step(); quiet();
    alu_cdb(3'd7, 32'h79);
    step(); quiet();
    step();
    check("flush_no_issue", 32'(bus.ALU_en), 32'd0);

    // Pause ignores writes and freezes issue
    wr(3'd6, 7'h30, 32'd3, 32'd4, ND, ND, 32'd0, 32'd0);
    bus.rdy_in = 1'b0;
    step(); quiet();
    step();
    check("pause_drop", 32'(bus.ALU_en), 32'd0);
    wr(3'd7, 7'h31, 32'd3, 32'd4, ND, ND, 32'h10, 32'h20);
    step(); quiet();
    bus.rdy_in = 1'b0;
    step();
    step();
    check("pause_hold", 32'(bus.ALU_en), 32'd0);
    bus.rdy_in = 1'b1;
    expect_issue(cyc + 1, 3'd7, 7'h31, 32'd3, 32'd4, 32'h10, 32'h20);
    step();
    check("pause_release", 32'(bus.ALU_en), 32'd1);
    step();

    // Asynchronous reset mid-cycle clears a pending issue and the stored entries
    wr(3'd1, 7'h40, 32'd0, 32'd1, 4'd5, ND, 32'd0, 32'd0);
    step();
    wr(3'd2, 7'h41, 32'd0, 32'd2, 4'd5, ND, 32'd0, 32'd0);
    step(); quiet();
    alu_cdb(3'd5, 32'h55);
    expect_issue(cyc + 2, 3'd1, 7'h40, 32'h55, 32'd1, 32'd0, 32'd0);
    step(); quiet();
    step();
    check("rst_pre", 32'(bus.ALU_en), 32'd1);
    #4;
    rst_n = 1'b0;
    #1;
    check("rst_async_en", 32'(bus.ALU_en), 32'd0);
    check("rst_async_rob", 32'(bus.ALU_robIndex), 32'd0);
    check("rst_async_vj", bus.ALU_Vj, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("rst_no_issue", 32'(bus.ALU_en), 32'd0);

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
